gun_pos_ctrl: RTL and testbench
===============================

Name: gun_pos_ctrl

Overview:
- Owns the Turkey Shoot crosshair position (gun_h/gun_v, 6 bits each) fed to williams2.
- Arbitrates three requesters: digital joystick, analog stick and mouse deltas.
- Sequences position updates on the game's 4 ms tick with repeat/acceleration, clamping and source ownership timeout.
- Sits in the emu top level between hps_io inputs and the williams2 gun_h/gun_v ports, on clk_sys (12 MHz).

Parameters:
- HOLD_TICKS, 2: ticks between joystick repeat steps after the first step.
- ACCEL_TICKS, 16: continuous-hold ticks after which the joystick step becomes 2.
- ANA_DEADZONE, 16: analog magnitude, strictly exceeded, that counts as activity.
- MOUSE_SHIFT, 2: mouse accumulator right-shift (sub-pixel scaling).
- SRC_TIMEOUT, 250: idle ticks before ownership returns to IDLE.
- RESET_POS, 32: gun_h/gun_v value after reset.

Ports:
- clk_sys  in  1  system clock, 12 MHz.
- reset  in  1  asynchronous, active-high reset.
- tick  in  1  cnt_4ms level from williams2; the block detects rising edges.
- joy_left, joy_right, joy_up, joy_down  in  1 each  digital directions.
- ana_x, ana_y  in  8  signed analog stick.
- ana_valid  in  1  analog inputs meaningful.
- mouse_dx, mouse_dy  in  9  signed deltas; dy positive = up.
- mouse_strobe  in  1  one-cycle pulse per mouse packet.
- gun_h, gun_v  out  6  crosshair position.
- src_o  out  2  current owner: 0 IDLE, 1 JOY, 2 ANA, 3 MOUSE.
- update_o  out  1  one-cycle pulse the cycle after gun_h or gun_v changes.

Behaviour:
- Reset (async, active-high): gun_h = gun_v = RESET_POS; src_o = IDLE; update_o = 0; all counters, accumulators and tick_d clear. Reset mid-hold discards the repeat state. Reset mid-accumulation discards the mouse remainder.
- Tick detect: tick_d registered; tick_p = tick & ~tick_d. All position changes happen only in the cycle where tick_p is 1. update_o follows one cycle later.
- Activity flags:
  - joy_act: any direction pressed.
  - ana_act: ana_valid and (|ana_x| > ANA_DEADZONE or |ana_y| > ANA_DEADZONE).
  - mouse_act: nonzero accumulator, or a nonzero strobe since the last tick.
- Owner FSM (evaluated on tick_p), states IDLE, JOY, ANA, MOUSE:
  - If the current owner is inactive, the owner becomes the highest-priority active source (MOUSE > JOY > ANA).
  - An active owner is never pre-empted.
  - Idle counter counts ticks with the owner inactive. At SRC_TIMEOUT the owner becomes IDLE and the counter clears.
  - Ownership change and the new owner's first move occur on the same tick.
- JOY, per axis (sub-module):
  - The first tick with a direction held steps by 1.
  - Subsequent steps occur every HOLD_TICKS ticks.
  - hold_cnt saturates at ACCEL_TICKS; once saturated the step is 2.
  - Left/up decrement; right/down increment.
  - Both opposite directions held on one axis: no move, axis counters clear.
  - Release clears the counters.
- ANA (absolute mode): gun_h = {~ana_x[7], ana_x[6:2]}, gun_v = {~ana_y[7], ana_y[6:2]}.
- MOUSE:
  - Accumulators acc_x/acc_y are 12-bit signed, saturating at ±2047.
  - Each strobe adds dx to acc_x and subtracts dy from acc_y.
  - On tick: step = acc >>> MOUSE_SHIFT; acc <= acc − (step << MOUSE_SHIFT), so the remainder is kept.
  - A strobe coinciding with tick_p is accumulated after the step, i.e. it is applied on the next tick.
  - Accumulators keep filling while not owner, and are cleared when MOUSE loses ownership.
- Arithmetic: new position = old + step computed in 13-bit signed, then clamped to 0..63. No wrap-around ever.
- A position write with an unchanged value produces no update_o.

Decomposition:
- Package gun_ctrl_pkg:
  - src_t enum (IDLE/JOY/ANA/MOUSE, 2 bits).
  - GUN_W = 6, GUN_MAX = 63.
  - Function clamp_pos (13-bit signed in, 6-bit out).
- Sub-module gun_axis_joy, instantiated once per axis.
  - Inputs: dec, inc, tick_p, en.
  - Output: signed step −2..+2.
  - Contains the hold and repeat counters.
- Top level holds the tick detect, owner FSM, mouse accumulators, clamp and position registers.

Test Plan:
- Reset: assert reset mid-simulation → gun_h = gun_v = 32, src_o = 0, update_o = 0 asynchronously, before the next clk edge.
- Joystick right held 20 ticks:
  - Tick 1 → gun_h 33, src_o = 1.
  - Then +1 every 2nd tick until 16 hold ticks.
  - Then +2 per step.
  - Clamps at 63, and update_o stops once clamped.
- Left+right together for 5 ticks → gun_h unchanged, no update_o. Release, then left → 1 on first tick.
- Mouse:
  - 3 strobes dx = +5 between ticks → acc 15, step 3, gun_h 32 → 35, remainder 3.
  - Next tick with a strobe coincident, dx = +1 → step 0 that tick; the following tick applies 4 → step 1.
- Priority/timeout:
  - Joystick held, mouse strobe dx = +8 → owner stays JOY while held.
  - Release → next tick owner MOUSE, gun_h += 2.
  - 250 idle ticks → src_o = 0.
- Analog: ana_valid, ana_x = +100, owner IDLE → gun_h = 57; ana_x = −128 → gun_h = 0; |ana_x| = 16 → no ownership taken.

Source files
------------

// File: rtl/gun_ctrl_pkg.sv
// Shared types and helpers for the Turkey Shoot crosshair controller.
// Owner encoding, position width and the 13-bit to 0..63 clamp.
package gun_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    JOY   = 2'd1,
    ANA   = 2'd2,
    MOUSE = 2'd3
  } src_t;

  localparam int GUN_W   = 6;
  localparam int GUN_MAX = 63;

  function automatic logic [GUN_W-1:0] clamp_pos(
    input logic signed [12:0] v
  );
    if (v < 13'sd0)  return '0;
    if (v > 13'sd63) return GUN_W'(GUN_MAX);
    return v[GUN_W-1:0];
  endfunction

endpackage

// File: rtl/gun_axis_joy.sv
// One joystick axis: first-press step, repeat every HOLD_TICKS, step 2 after ACCEL_TICKS.
// Ports: clk_sys, reset, dec, inc, tick_p, en in; step (signed -2..+2) out.
module gun_axis_joy
  import gun_ctrl_pkg::*;
#(
  parameter int HOLD_TICKS  = 2,
  parameter int ACCEL_TICKS = 16
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              dec,
  input  logic              inc,
  input  logic              tick_p,
  input  logic              en,
  output logic signed [2:0] step
);

  localparam int CW = $clog2(ACCEL_TICKS + 1);
  localparam int RW = $clog2(HOLD_TICKS + 1);

  logic [CW-1:0] hold_cnt, hold_nxt;
  logic [RW-1:0] rep_cnt, rep_nxt;
  logic          held, fire;
  logic [1:0]    mag;

  always_comb begin
    held     = en && (dec ^ inc);
    hold_nxt = hold_cnt;
    rep_nxt  = rep_cnt;
    fire     = 1'b0;
    if (!held) begin
      hold_nxt = '0;
      rep_nxt  = '0;
    end else if (tick_p) begin
      if (hold_cnt != CW'(ACCEL_TICKS))
        hold_nxt = hold_cnt + 1'b1;
      // first held tick moves at once, then every HOLD_TICKS
      if (hold_cnt == '0) begin
        fire    = 1'b1;
        rep_nxt = '0;
      end else if (rep_cnt == RW'(HOLD_TICKS - 1)) begin
        fire    = 1'b1;
        rep_nxt = '0;
      end else begin
        rep_nxt = rep_cnt + 1'b1;
      end
    end
    mag  = (hold_nxt == CW'(ACCEL_TICKS)) ? 2'd2 : 2'd1;
    step = '0;
    if (fire)
      step = inc ? $signed({1'b0, mag})
                 : -$signed({1'b0, mag});
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      hold_cnt <= '0;
      rep_cnt  <= '0;
    end else begin
      hold_cnt <= hold_nxt;
      rep_cnt  <= rep_nxt;
    end
  end

endmodule

// File: rtl/gun_pos_ctrl.sv
// Crosshair position owner: arbitrates joystick, analog and mouse on the 4 ms tick.
// Ports: clk_sys, reset, tick, joy_*, ana_*, mouse_* in; gun_h, gun_v, src_o, update_o out.
module gun_pos_ctrl
  import gun_ctrl_pkg::*;
#(
  parameter int HOLD_TICKS   = 2,
  parameter int ACCEL_TICKS  = 16,
  parameter int ANA_DEADZONE = 16,
  parameter int MOUSE_SHIFT  = 2,
  parameter int SRC_TIMEOUT  = 250,
  parameter int RESET_POS    = 32
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              tick,
  input  logic              joy_left,
  input  logic              joy_right,
  input  logic              joy_up,
  input  logic              joy_down,
  input  logic signed [7:0] ana_x,
  input  logic signed [7:0] ana_y,
  input  logic              ana_valid,
  input  logic signed [8:0] mouse_dx,
  input  logic signed [8:0] mouse_dy,
  input  logic              mouse_strobe,
  output logic [GUN_W-1:0]  gun_h,
  output logic [GUN_W-1:0]  gun_v,
  output logic [1:0]        src_o,
  output logic              update_o
);

  localparam int IW = $clog2(SRC_TIMEOUT + 1);

  function automatic logic [7:0] mag8(
    input logic signed [7:0] v
  );
    return v[7] ? 8'(-v) : 8'(v);
  endfunction

  function automatic logic signed [11:0] sat12(
    input logic signed [12:0] v
  );
    if (v > 13'sd2047)  return 12'sd2047;
    if (v < -13'sd2047) return -12'sd2047;
    return v[11:0];
  endfunction

  logic                     tick_d, tick_p;
  src_t                     owner, owner_n;
  logic [IW-1:0]            idle_cnt, idle_n;
  logic signed [11:0]       acc_x, acc_y;
  logic signed [11:0]       accx_n, accy_n;
  logic signed [11:0]       mstep_x, mstep_y;
  logic                     mflag, mflag_n;
  logic                     joy_act, ana_act;
  logic                     mouse_act, own_act;
  logic                     joy_en;
  logic signed [2:0]        jstep_h, jstep_v;
  logic [12:0]              del_h, del_v;
  logic [GUN_W-1:0]         pos_h_n, pos_v_n;

  gun_axis_joy #(
    .HOLD_TICKS (HOLD_TICKS),
    .ACCEL_TICKS(ACCEL_TICKS)
  ) u_joy_h (
    .clk_sys(clk_sys),
    .reset  (reset),
    .dec    (joy_left),
    .inc    (joy_right),
    .tick_p (tick_p),
    .en     (joy_en),
    .step   (jstep_h)
  );

  gun_axis_joy #(
    .HOLD_TICKS (HOLD_TICKS),
    .ACCEL_TICKS(ACCEL_TICKS)
  ) u_joy_v (
    .clk_sys(clk_sys),
    .reset  (reset),
    .dec    (joy_up),
    .inc    (joy_down),
    .tick_p (tick_p),
    .en     (joy_en),
    .step   (jstep_v)
  );

  always_comb begin
    tick_p    = tick & ~tick_d;
    joy_act   = joy_left | joy_right
              | joy_up | joy_down;
    ana_act   = ana_valid &&
                (mag8(ana_x) > 8'(ANA_DEADZONE) ||
                 mag8(ana_y) > 8'(ANA_DEADZONE));
    mouse_act = (acc_x != '0) || (acc_y != '0)
              || mflag;
    own_act   = 1'b0;
    case (owner)
      JOY:     own_act = joy_act;
      ANA:     own_act = ana_act;
      MOUSE:   own_act = mouse_act;
      default: own_act = 1'b0;
    endcase

    owner_n = owner;
    idle_n  = idle_cnt;
    if (tick_p) begin
      if (own_act) begin
        idle_n = '0;
      end else if (mouse_act) begin
        owner_n = MOUSE;
        idle_n  = '0;
      end else if (joy_act) begin
        owner_n = JOY;
        idle_n  = '0;
      end else if (ana_act) begin
        owner_n = ANA;
        idle_n  = '0;
      end else if (owner != IDLE) begin
        if (idle_cnt == IW'(SRC_TIMEOUT - 1)) begin
          owner_n = IDLE;
          idle_n  = '0;
        end else begin
          idle_n = idle_cnt + 1'b1;
        end
      end
    end
    joy_en = (owner_n == JOY);

    // whole pixels leave the accumulator, the sub-pixel remainder stays
    mstep_x = acc_x >>> MOUSE_SHIFT;
    mstep_y = acc_y >>> MOUSE_SHIFT;

    del_h   = '0;
    del_v   = '0;
    pos_h_n = gun_h;
    pos_v_n = gun_v;
    accx_n  = acc_x;
    accy_n  = acc_y;
    mflag_n = mflag;
    if (tick_p) begin
      mflag_n = 1'b0;
      case (owner_n)
        JOY: begin
          del_h = {{10{jstep_h[2]}}, jstep_h};
          del_v = {{10{jstep_v[2]}}, jstep_v};
        end
        MOUSE: begin
          del_h  = {mstep_x[11], mstep_x};
          del_v  = {mstep_y[11], mstep_y};
          accx_n = acc_x - (mstep_x <<< MOUSE_SHIFT);
          accy_n = acc_y - (mstep_y <<< MOUSE_SHIFT);
        end
        default: ;
      endcase
      if (owner == MOUSE && owner_n != MOUSE) begin
        accx_n = '0;
        accy_n = '0;
      end
      if (owner_n == ANA) begin
        pos_h_n = {~ana_x[7], ana_x[6:2]};
        pos_v_n = {~ana_y[7], ana_y[6:2]};
      end else begin
        pos_h_n = clamp_pos({7'b0, gun_h} + del_h);
        pos_v_n = clamp_pos({7'b0, gun_v} + del_v);
      end
    end

    // a strobe on the tick cycle lands after the step
    if (mouse_strobe) begin
      accx_n = sat12({accx_n[11], accx_n}
             + {{4{mouse_dx[8]}}, mouse_dx});
      accy_n = sat12({accy_n[11], accy_n}
             - {{4{mouse_dy[8]}}, mouse_dy});
      if (mouse_dx != '0 || mouse_dy != '0)
        mflag_n = 1'b1;
    end
  end

  assign src_o = owner;

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      tick_d   <= 1'b0;
      owner    <= IDLE;
      idle_cnt <= '0;
      acc_x    <= '0;
      acc_y    <= '0;
      mflag    <= 1'b0;
      gun_h    <= GUN_W'(RESET_POS);
      gun_v    <= GUN_W'(RESET_POS);
      update_o <= 1'b0;
    end else begin
      tick_d   <= tick;
      owner    <= owner_n;
      idle_cnt <= idle_n;
      acc_x    <= accx_n;
      acc_y    <= accy_n;
      mflag    <= mflag_n;
      gun_h    <= pos_h_n;
      gun_v    <= pos_v_n;
      update_o <= (pos_h_n != gun_h)
               || (pos_v_n != gun_v);
    end
  end

endmodule

// File: tb/tb_gun_pos_ctrl.sv
// Self-checking bench for gun_pos_ctrl: directed steps plus random traffic.
// Expected values come from a tick-level behavioural model of the crosshair rules.
module tb_gun_pos_ctrl;

  localparam int HOLD  = 2;
  localparam int ACCEL = 16;
  localparam int DZ    = 16;
  localparam int MSH   = 2;
  localparam int TMO   = 250;
  localparam int RP    = 32;

  logic clk_sys = 1'b0;
  logic reset = 1'b1;
  logic tick = 1'b0;
  logic joy_left = 1'b0, joy_right = 1'b0;
  logic joy_up = 1'b0, joy_down = 1'b0;
  logic signed [7:0] ana_x = '0, ana_y = '0;
  logic ana_valid = 1'b0;
  logic signed [8:0] mouse_dx = '0, mouse_dy = '0;
  logic mouse_strobe = 1'b0;
  logic [5:0] gun_h, gun_v;
  logic [1:0] src_o;
  logic update_o;

  int n_tests = 0;
  int n_fail = 0;

  int m_h, m_v, m_own, m_idle;
  int m_kh, m_kv, m_ax, m_ay;
  bit m_flag, m_upd;

  gun_pos_ctrl dut (
    .clk_sys     (clk_sys),
    .reset       (reset),
    .tick        (tick),
    .joy_left    (joy_left),
    .joy_right   (joy_right),
    .joy_up      (joy_up),
    .joy_down    (joy_down),
    .ana_x       (ana_x),
    .ana_y       (ana_y),
    .ana_valid   (ana_valid),
    .mouse_dx    (mouse_dx),
    .mouse_dy    (mouse_dy),
    .mouse_strobe(mouse_strobe),
    .gun_h       (gun_h),
    .gun_v       (gun_v),
    .src_o       (src_o),
    .update_o    (update_o)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic chk(input string tag, input string what,
                     input int got, input int want);
    n_tests++;
    assert (got === want) else begin
      n_fail++;
      $error("FAIL %s.%s got %0d want %0d",
             tag, what, got, want);
    end
  endtask

  function automatic int clampi(input int v);
    return (v < 0) ? 0 : ((v > 63) ? 63 : v);
  endfunction

  function automatic int sat(input int v);
    return (v > 2047) ? 2047 : ((v < -2047) ? -2047 : v);
  endfunction

  function automatic int absi(input int v);
    return (v < 0) ? -v : v;
  endfunction

  // k = number of consecutive ticks this axis has been held as owner
  function automatic int joy_step(input int k, input bit neg);
    int m;
    if ((k - 1) % HOLD != 0) return 0;
    m = (k >= ACCEL) ? 2 : 1;
    return neg ? -m : m;
  endfunction

  task automatic model_reset();
    m_h = RP; m_v = RP; m_own = 0; m_idle = 0;
    m_kh = 0; m_kv = 0; m_ax = 0; m_ay = 0;
    m_flag = 0; m_upd = 0;
  endtask

  task automatic m_strobe(input int dx, input int dy);
    m_ax = sat(m_ax + dx);
    m_ay = sat(m_ay - dy);
    if (dx != 0 || dy != 0) m_flag = 1;
  endtask

  task automatic model_tick();
    bit ja, aa, ma, oa;
    int prev, nh, nv, dh, dv;
    ja = joy_left | joy_right | joy_up | joy_down;
    aa = ana_valid && (absi(int'(ana_x)) > DZ ||
                       absi(int'(ana_y)) > DZ);
    ma = (m_ax != 0) || (m_ay != 0) || m_flag;
    prev = m_own;
    oa = (prev == 1 && ja) || (prev == 2 && aa) ||
         (prev == 3 && ma);
    if (oa) m_idle = 0;
    else if (ma) begin m_own = 3; m_idle = 0; end
    else if (ja) begin m_own = 1; m_idle = 0; end
    else if (aa) begin m_own = 2; m_idle = 0; end
    else if (prev != 0) begin
      m_idle++;
      if (m_idle == TMO) begin m_own = 0; m_idle = 0; end
    end
    nh = m_h; nv = m_v;
    if (m_own == 1) begin
      if (joy_left ^ joy_right) begin
        m_kh++;
        nh = clampi(m_h + joy_step(m_kh, joy_left));
      end else m_kh = 0;
      if (joy_up ^ joy_down) begin
        m_kv++;
        nv = clampi(m_v + joy_step(m_kv, joy_up));
      end else m_kv = 0;
    end else begin
      m_kh = 0; m_kv = 0;
    end
    if (m_own == 2) begin
      nh = (int'(ana_x) + 128) / 4;
      nv = (int'(ana_y) + 128) / 4;
    end
    if (m_own == 3) begin
      dh = m_ax >>> MSH;
      dv = m_ay >>> MSH;
      m_ax = m_ax - dh * (1 << MSH);
      m_ay = m_ay - dv * (1 << MSH);
      nh = clampi(m_h + dh);
      nv = clampi(m_v + dv);
    end else if (prev == 3) begin
      m_ax = 0; m_ay = 0;
    end
    m_flag = 0;
    m_upd = (nh != m_h) || (nv != m_v);
    m_h = nh; m_v = nv;
  endtask

  task automatic do_tick(input string tag, input bit co = 0,
                         input int dx = 0, input int dy = 0);
    model_tick();
    @(negedge clk_sys);
    tick = 1'b1;
    if (co) begin
      mouse_strobe = 1'b1;
      mouse_dx = 9'(dx);
      mouse_dy = 9'(dy);
    end
    @(negedge clk_sys);
    tick = 1'b0;
    mouse_strobe = 1'b0;
    if (co) m_strobe(dx, dy);
    chk(tag, "gun_h", int'(gun_h), m_h);
    chk(tag, "gun_v", int'(gun_v), m_v);
    chk(tag, "src", int'(src_o), m_own);
    chk(tag, "upd", int'(update_o), int'(m_upd));
    @(negedge clk_sys);
    chk(tag, "upd_fall", int'(update_o), 0);
  endtask

  task automatic do_strobe(input int dx, input int dy);
    @(negedge clk_sys);
    mouse_strobe = 1'b1;
    mouse_dx = 9'(dx);
    mouse_dy = 9'(dy);
    @(negedge clk_sys);
    mouse_strobe = 1'b0;
    m_strobe(dx, dy);
  endtask

  task automatic set_joy(input bit l, input bit r,
                         input bit u, input bit d);
    @(negedge clk_sys);
    joy_left = l; joy_right = r;
    joy_up = u; joy_down = d;
    if (!(l ^ r)) m_kh = 0;
    if (!(u ^ d)) m_kv = 0;
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk_sys);
    #2 reset = 1'b1;
    #1;
    chk(tag, "rst_h", int'(gun_h), RP);
    chk(tag, "rst_v", int'(gun_v), RP);
    chk(tag, "rst_src", int'(src_o), 0);
    chk(tag, "rst_upd", int'(update_o), 0);
    model_reset();
    @(negedge clk_sys);
    reset = 1'b0;
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clk_sys);
    chk("init", "h", int'(gun_h), RP);
    chk("init", "src", int'(src_o), 0);
    chk("init", "upd", int'(update_o), 0);
    reset = 1'b0;

    // joystick right held until clamped
    set_joy(0, 1, 0, 0);
    do_tick("joy1");
    chk("joy1", "h_const", int'(gun_h), 33);
    chk("joy1", "src_const", int'(src_o), 1);
    for (int i = 2; i <= 20; i++) do_tick("joyR");
    chk("joy20", "h_const", int'(gun_h), 44);
    for (int i = 21; i <= 44; i++) do_tick("joyR");
    chk("joy44", "h_const", int'(gun_h), 63);

    // both horizontal directions cancel
    set_joy(1, 1, 0, 0);
    for (int i = 0; i < 5; i++) do_tick("joyLR");
    chk("joyLR", "h_const", int'(gun_h), 63);
    set_joy(0, 0, 0, 0);
    set_joy(1, 0, 0, 0);
    do_tick("joyL1");
    chk("joyL1", "h_const", int'(gun_h), 62);
    for (int i = 0; i < 6; i++) do_tick("joyL");

    // reset mid-hold drops the repeat state
    do_reset("rst_hold");
    do_tick("joyL_rst");
    chk("joyL_rst", "h_const", int'(gun_h), 31);
    set_joy(0, 0, 0, 0);

    // mouse accumulation with remainder
    do_reset("rst_m");
    for (int i = 0; i < 3; i++) do_strobe(5, 0);
    do_tick("m1");
    chk("m1", "h_const", int'(gun_h), 35);
    chk("m1", "src_const", int'(src_o), 3);
    do_tick("m2", 1, 1, 0);
    chk("m2", "h_const", int'(gun_h), 35);
    do_tick("m3");
    chk("m3", "h_const", int'(gun_h), 36);

    // reset mid-accumulation drops the remainder
    do_reset("rst_acc");
    do_strobe(3, 0);
    do_reset("rst_acc2");
    do_tick("m_rst");
    chk("m_rst", "src_const", int'(src_o), 0);

    // owner priority and timeout
    set_joy(0, 1, 0, 0);
    do_tick("p1");
    do_strobe(8, 0);
    do_tick("p2");
    do_tick("p3");
    chk("p3", "src_const", int'(src_o), 1);
    chk("p3", "h_const", int'(gun_h), 34);
    set_joy(0, 0, 0, 0);
    do_tick("p4");
    chk("p4", "src_const", int'(src_o), 3);
    chk("p4", "h_const", int'(gun_h), 36);
    for (int i = 1; i < TMO; i++) do_tick("idle");
    chk("idle249", "src_const", int'(src_o), 3);
    do_tick("idle250");
    chk("idle250", "src_const", int'(src_o), 0);

    // analog absolute mode and deadzone edge
    do_reset("rst_a");
    @(negedge clk_sys);
    ana_valid = 1'b1; ana_x = 8'sd100; ana_y = 8'sd0;
    do_tick("a1");
    chk("a1", "h_const", int'(gun_h), 57);
    chk("a1", "src_const", int'(src_o), 2);
    @(negedge clk_sys);
    ana_x = -8'sd128;
    do_tick("a2");
    chk("a2", "h_const", int'(gun_h), 0);
    do_reset("rst_a2");
    @(negedge clk_sys);
    ana_x = 8'sd16; ana_y = -8'sd16;
    do_tick("a3");
    chk("a3", "src_const", int'(src_o), 0);
    @(negedge clk_sys);
    ana_x = -8'sd17;
    do_tick("a4");
    chk("a4", "h_const", int'(gun_h), 27);
    @(negedge clk_sys);
    ana_valid = 1'b0;

    // random joystick / analog traffic
    do_reset("rst_r1");
    for (int i = 0; i < 150; i++) begin
      case ($urandom_range(0, 3))
        0: set_joy(1'($urandom), 1'($urandom),
                   1'($urandom), 1'($urandom));
        1: begin
          @(negedge clk_sys);
          ana_valid = 1'($urandom);
          ana_x = 8'($urandom);
          ana_y = 8'($urandom);
        end
        2: set_joy(0, 0, 0, 0);
        default: ;
      endcase
      do_tick("rnd1");
    end

    // random traffic including mouse packets
    for (int i = 0; i < 100; i++) begin
      case ($urandom_range(0, 4))
        0: set_joy(1'($urandom), 1'($urandom),
                   1'($urandom), 1'($urandom));
        1: begin
          @(negedge clk_sys);
          ana_valid = 1'($urandom);
          ana_x = 8'($urandom);
          ana_y = 8'($urandom);
        end
        2: do_strobe(int'($urandom_range(0, 80)) - 40,
                     int'($urandom_range(0, 80)) - 40);
        3: set_joy(0, 0, 0, 0);
        default: ;
      endcase
      if ($urandom_range(0, 3) == 0)
        do_tick("rnd2c", 1,
                int'($urandom_range(0, 510)) - 255,
                int'($urandom_range(0, 510)) - 255);
      else
        do_tick("rnd2");
    end

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
